// File: rtl/mdu_ctrl_if.sv
// Handshake bundle between the EX stage, the mult/div sequencer and the external multiplier/divider.
interface mdu_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, mul_result, div_ready, div_result,
    input  mul_signed, mul_a, mul_b, div_start, div_signed, div_op1, div_op2, div_annul,
           stall_req, hilo_we, hi_wdata, lo_wdata, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, mul_result, div_ready, div_result,
    output mul_signed, mul_a, mul_b, div_start, div_signed, div_op1, div_op2, div_annul,
           stall_req, hilo_we, hi_wdata, lo_wdata, busy
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Sequencer for mult/multu/div/divu: stalls EX, drives the multiplier/divider, writes HI/LO once.
// Optional MDU_DIV_ZERO_BYPASS_EN: divide-by-zero skips the divider and writes HI=a, LO=all-ones.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  io_mdu
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MUL_WAIT = 2'd1;
  localparam logic [1:0] S_DIV_WAIT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_result;

  logic w_accept;
  logic w_div_zero;

  assign w_accept = (r_state == S_IDLE) && io_mdu.req_valid && !io_mdu.flush;

`ifdef MDU_DIV_ZERO_BYPASS_EN
  assign w_div_zero = io_mdu.req_op[1] && (io_mdu.req_b == 32'd0);
`else
  assign w_div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_op     <= 2'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= io_mdu.req_op;
            r_a  <= io_mdu.req_a;
            r_b  <= io_mdu.req_b;
            if (w_div_zero) begin
              r_result <= {io_mdu.req_a, 32'hFFFF_FFFF};
              r_state  <= S_DONE;
            end else if (io_mdu.req_op[1]) begin
              r_state <= S_DIV_WAIT;
            end else begin
              r_cnt   <= 4'(MUL_LAT);
              r_state <= S_MUL_WAIT;
            end
          end
        end
        S_MUL_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (io_mdu.flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_result <= io_mdu.mul_result;
            r_state  <= S_DONE;
          end
        end
        S_DIV_WAIT: begin
          if (io_mdu.flush) begin
            r_state <= S_IDLE;
          end else if (io_mdu.div_ready) begin
            r_result <= io_mdu.div_result;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst is held, even before the state register clears.
  always_comb begin
    io_mdu.stall_req  = 1'b0;
    io_mdu.busy       = 1'b0;
    io_mdu.mul_signed = 1'b0;
    io_mdu.mul_a      = 32'd0;
    io_mdu.mul_b      = 32'd0;
    io_mdu.div_start  = 1'b0;
    io_mdu.div_signed = 1'b0;
    io_mdu.div_op1    = 32'd0;
    io_mdu.div_op2    = 32'd0;
    io_mdu.div_annul  = 1'b0;
    io_mdu.hilo_we    = 1'b0;
    io_mdu.hi_wdata   = 32'd0;
    io_mdu.lo_wdata   = 32'd0;
    if (!rst) begin
      io_mdu.busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: io_mdu.stall_req = io_mdu.req_valid && !io_mdu.flush;
        S_MUL_WAIT: begin
          io_mdu.stall_req  = 1'b1;
          io_mdu.mul_a      = r_a;
          io_mdu.mul_b      = r_b;
          io_mdu.mul_signed = (r_op == 2'b00);
        end
        S_DIV_WAIT: begin
          io_mdu.stall_req  = 1'b1;
          io_mdu.div_op1    = r_a;
          io_mdu.div_op2    = r_b;
          io_mdu.div_signed = (r_op == 2'b10);
          io_mdu.div_start  = !io_mdu.div_ready && !io_mdu.flush;
          io_mdu.div_annul  = io_mdu.flush;
        end
        S_DONE: begin
          io_mdu.hilo_we = !io_mdu.flush;
          if (!io_mdu.flush) begin
            io_mdu.hi_wdata = r_result[63:32];
            io_mdu.lo_wdata = r_result[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus random ops against an arithmetic HI/LO reference.
module tb_mdu_ctrl;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   dlat   = 4;
  int   dcnt   = 0;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_mdu (bus.slave)
  );

  always #5 clk = ~clk;

  // HI/LO as the ISA defines them; divide-by-zero yields {a, all-ones} from the bench divider.
  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Combinational multiplier; latency is enforced by the sequencer's counter.
  always_comb bus.mul_result = ref_hilo(bus.mul_signed ? 2'b00 : 2'b01, bus.mul_a, bus.mul_b);

  // Divider raises ready after dlat cycles of div_start.
  always @(posedge clk) begin
    if (rst || !bus.div_start) begin
      dcnt          <= 0;
      bus.div_ready <= 1'b0;
    end else if (dcnt + 1 >= dlat) begin
      bus.div_ready  <= 1'b1;
      bus.div_result <= ref_hilo(bus.div_signed ? 2'b10 : 2'b11, bus.div_op1, bus.div_op2);
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(bus.busy), 64'd0);
    chk({tag, "_stall"}, 64'(bus.stall_req), 64'd0);
    chk({tag, "_we"},    64'(bus.hilo_we), 64'd0);
    chk({tag, "_start"}, 64'(bus.div_start), 64'd0);
    chk({tag, "_annul"}, 64'(bus.div_annul), 64'd0);
    chk({tag, "_ops"},   64'({bus.mul_a, bus.div_op1}), 64'd0);
  endtask

  // Issues one op and follows it cycle by cycle; flush_at=0 means no flush, else flush in that cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int flush_at);
    logic [63:0] exp;
    int  done_at;
    bit  byp;
    bit  seen_start;
    bit  finished;
    dlat = lat;
    exp  = ref_hilo(op, a, b);
    byp  = 1'b0;
`ifdef MDU_DIV_ZERO_BYPASS_EN
    byp = op[1] && (b == 32'd0);
`endif
    done_at = byp ? 1 : (op[1] ? lat + 2 : MUL_LAT + 1);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    chk("accept_stall", 64'(bus.stall_req), 64'd1);
    seen_start = 1'b0;
    finished   = 1'b0;
    for (int c = 1; c <= done_at && !finished; c++) begin
      @(negedge clk);
      if (c == flush_at) begin
        bus.flush = 1'b1;
        #1;
        chk("flush_no_we", 64'(bus.hilo_we), 64'd0);
        chk("flush_annul", 64'(bus.div_annul), 64'(op[1] && !byp && c < done_at));
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("flush_idle", 64'(bus.busy), 64'd0);
        chk("flush_annul_off", 64'(bus.div_annul), 64'd0);
        finished = 1'b1;
      end else if (c == done_at) begin
        chk("done_we", 64'(bus.hilo_we), 64'd1);
        chk("done_hilo", {bus.hi_wdata, bus.lo_wdata}, exp);
        chk("done_stall", 64'(bus.stall_req), 64'd0);
        chk("done_busy", 64'(bus.busy), 64'd1);
        chk("div_start_used", 64'(seen_start), 64'(op[1] && !byp));
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("after_done_busy", 64'(bus.busy), 64'd0);
        chk("after_done_we", 64'(bus.hilo_we), 64'd0);
        finished = 1'b1;
      end else begin
        chk("wait_stall", 64'(bus.stall_req), 64'd1);
        chk("wait_no_we", 64'(bus.hilo_we), 64'd0);
        chk("wait_start", 64'(bus.div_start), 64'(op[1] && c <= lat));
        if (bus.div_start) seen_start = 1'b1;
        if (c == 1) begin
          if (op[1]) begin
            chk("div_ops", {bus.div_op1, bus.div_op2}, {a, b});
            chk("div_signed", 64'(bus.div_signed), 64'(op == 2'b10));
            chk("mul_idle_ops", {bus.mul_a, bus.mul_b}, 64'd0);
          end else begin
            chk("mul_ops", {bus.mul_a, bus.mul_b}, {a, b});
            chk("mul_signed", 64'(bus.mul_signed), 64'(op == 2'b00));
            chk("div_idle_ops", {bus.div_op1, bus.div_op2}, 64'd0);
          end
        end
      end
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat, fl;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'd0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.flush      = 1'b0;
    bus.div_result = 64'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // mult -3*5, divu 100/7 with a 33-cycle divider, div -7/2
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 4, 0);
    do_op(2'b11, 32'd100, 32'd7, 33, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 6, 0);

    // flush on the 10th DIV_WAIT cycle, then multu 3*4
    do_op(2'b10, 32'd1000, 32'd3, 33, 10);
    do_op(2'b01, 32'd3, 32'd4, 4, 0);

    // flush while idle: no acceptance, no stall
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    #1;
    chk("idle_flush_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    chk("idle_flush_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;

    // flush landing on DONE suppresses the write
    do_op(2'b00, 32'd7, 32'd9, 4, MUL_LAT + 1);

    // reset in the middle of a division
    @(negedge clk);
    dlat = 40;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    bus.req_a     = 32'd55;
    bus.req_b     = 32'd5;
    repeat (6) @(negedge clk);
    chk("mid_div_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_release");
    @(negedge clk);
    chk_all_zero("rst_after");

    // divu 0/0
    do_op(2'b11, 32'd0, 32'd0, 5, 0);

    // random ops, occasional flush
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (op[1] && b == 32'd0) b = 32'd1;
      lat = $urandom_range(1, 12);
      fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, op[1] ? lat + 2 : MUL_LAT + 1) : 0;
      do_op(op, a, b, lat, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter: MUL_LAT, default 2, cycles from mul operand presentation to valid mul_result (legal 1..15).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port: req_valid  input  1  EX holds a mult/multu/div/divu instruction.
REQ-005 SHALL have port: req_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port: req_a, req_b  input  32 each  rs and rt operands.
REQ-007 SHALL have port: flush  input  1  cancel the in-flight operation.
REQ-008 SHALL have port: mul_signed, mul_a, mul_b  output  1/32/32  drive the multiplier.
REQ-009 SHALL have port: mul_result  input  64  multiplier product.
REQ-010 SHALL have port: div_start, div_signed, div_op1, div_op2, div_annul  output  1/1/32/32/1  drive the divider.
REQ-011 SHALL have port: div_ready, div_result  input  1/64  divider done flag and {remainder, quotient}.
REQ-012 SHALL have port: stall_req  output  1  pipeline stall request.
REQ-013 SHALL have port: hilo_we, hi_wdata, lo_wdata  output  1/32/32  HI/LO write.
REQ-014 SHALL have port: busy  output  1  state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, MUL_WAIT, DIV_WAIT and DONE.
REQ-016 In IDLE with req_valid=1 and flush=0, SHALL latch op, req_a and req_b; SHALL go to MUL_WAIT for op[1]=0 and to DIV_WAIT for op[1]=1.
REQ-017 SHALL drive stall_req combinationally high in IDLE while req_valid=1 and flush=0, and in MUL_WAIT and DIV_WAIT; SHALL drive it low in DONE.
REQ-018 SHALL drive mul_a, mul_b and mul_signed (1 for mult) from the latched values throughout MUL_WAIT.
REQ-019 SHALL load a 4-bit counter with MUL_LAT on entry to MUL_WAIT and decrement it every cycle; when the counter reaches 1, SHALL capture mul_result and go to DONE.
REQ-020 SHALL hold div_start=1 in DIV_WAIT while div_ready=0, with div_op1, div_op2 and div_signed (1 for div) held from the latched values.
REQ-021 In DIV_WAIT with div_ready=1, SHALL capture div_result, deassert div_start the same cycle, and go to DONE.
REQ-022 SHALL spend exactly one cycle in DONE with hilo_we=1, hi_wdata=result[63:32] and lo_wdata=result[31:0], then return to IDLE.
REQ-023 SHALL ignore req_valid in DONE; the released instruction leaves EX on that edge and SHALL NOT retrigger.
REQ-024 In MUL_WAIT or DIV_WAIT with flush=1, SHALL go to IDLE without hilo_we; in DIV_WAIT, div_annul=1 for that one cycle.
REQ-025 With flush=1 in IDLE, SHALL accept no request; with flush=1 in DONE, SHALL suppress hilo_we.
REQ-026 SHALL hold hilo_we=0, div_start=0 and div_annul=0 outside the cases stated above; SHALL drive operand outputs to zero in IDLE.

Reset
REQ-027 When rst=1 at a clock edge, SHALL enter IDLE from any state, including mid-division, clearing counter, latched operands and captured result.
REQ-028 During and after reset, all outputs SHALL be 0 until the next accepted request; div_annul SHALL be 0.

Configuration
REQ-029 The macro MDU_DIV_ZERO_BYPASS_EN, when defined, SHALL make a div/divu with req_b=0 go directly from IDLE to DONE with HI=req_a and LO=32'hFFFF_FFFF, never asserting div_start.
REQ-030 When MDU_DIV_ZERO_BYPASS_EN is undefined, divide-by-zero SHALL follow the normal DIV_WAIT path and write whatever div_result returns.

Verification
REQ-031 mult, a=32'hFFFF_FFFD (-3), b=5, MUL_LAT=2, accepted at cycle 0 -> hilo_we at cycle 3, HI=FFFF_FFFF, LO=FFFF_FFF1; stall_req high for cycles 0-2.
REQ-032 divu, a=100, b=7, divider ready after 33 cycles -> div_start high until ready; one DONE cycle with HI=2, LO=14; then busy=0.
REQ-033 div, a=-7, b=2 -> div_signed=1; HI=FFFF_FFFF, LO=FFFF_FFFD.
REQ-034 div accepted, flush at 10th DIV_WAIT cycle -> div_annul pulse of one cycle, no hilo_we, IDLE next cycle; a following multu 3*4 completes with LO=12.
REQ-035 rst asserted mid-DIV_WAIT -> IDLE next edge with all outputs 0; divu 0/0 with MDU_DIV_ZERO_BYPASS_EN defined -> DONE the cycle after accept, HI=0, LO=FFFF_FFFF, div_start never high.
